irq_pend4: RTL

Four-channel request capture and pending register that sits directly upstream of the 4-to-2 priority encoder. It synchronises asynchronous request lines and latches rising edges as sticky pending bits. It drives the masked pending vector into the encoder's `in` and clears the serviced bit when the consumer acknowledges the encoder's `code`. It also reports a registered interrupt summary and per-channel overflow.

---
 rtl/irq_pend4.sv | 62 ++++++
 1 files changed

// File: rtl/irq_pend4.sv
// Four-channel request capture: 2-flop synchroniser, edge/level detect, sticky pending
// bits cleared by acknowledge, masked pending vector, registered irq summary and overflow.
module irq_pend4 #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_code,
  input  logic       ovf_clr,
  output logic [3:0] raw_pend,
  output logic [3:0] pend,
  output logic       irq,
  output logic [3:0] ovf,
  output logic       ack_miss
);

  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] prev;
  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] ovf_next;

  assign pend = raw_pend & ~mask;

  always_comb begin
    rise     = '0;
    clr      = '0;
    ovf_next = '0;
    for (int i = 0; i < 4; i++) begin
      rise[i] = EDGE ? (s2[i] & ~prev[i]) : s2[i];
      clr[i]  = ack && (ack_code == i[1:0]);
      // a fresh overflow on the same edge as ovf_clr survives
      if (EDGE)
        ovf_next[i] = (ovf[i] & ~ovf_clr) | (rise[i] & raw_pend[i] & ~clr[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      raw_pend <= '0;
      ovf      <= '0;
      irq      <= 1'b0;
      ack_miss <= 1'b0;
    end else begin
      s1       <= req;
      s2       <= s1;
      prev     <= s2;
      raw_pend <= rise | (raw_pend & ~clr);
      ovf      <= ovf_next;
      irq      <= |pend;
      ack_miss <= ack & ~raw_pend[ack_code];
    end
  end

endmodule
